// File: rtl/run_control_pkg.sv
// run_control_pkg: shared definitions for the run/halt/step front-panel controller.
//   - rc_state_t   : FSM state encoding (HALTED=0, RUNNING=1, STOPPING=2, STEP=3)
//   - DEBOUNCE_CYCLES_DEF / ADDR_W_DEF : default parameter values
//   - is_running() : decode of the "processor is free-running" condition
package run_control_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int ADDR_W_DEF          = 16;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2,
    ST_STEP     = 2'd3
  } rc_state_t;

  // STOPPING still counts as running: the processor clock keeps going until
  // the next instruction boundary.
  function automatic logic is_running(input rc_state_t s);
    return (s == ST_RUNNING) || (s == ST_STOPPING);
  endfunction

endpackage

// File: rtl/run_control_switch_debounce.sv
// switch_debounce: conditions one bouncing, asynchronous, active-high switch.
//   2-FF synchroniser -> debounce counter -> one-cycle rising-edge event.
//   The debounced level only follows the synchronised input after
//   DEBOUNCE_CYCLES consecutive samples that differ from the current level.
//   A clean switch edge yields rise_ev 2+DEBOUNCE_CYCLES cycles later.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-high reset (clears everything)
//   sw      in  raw switch input
//   rise_ev out one-cycle pulse on a debounced 0->1 transition (registered)
module switch_debounce
  import run_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic rise_ev
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, debounce counter and edge event.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      rise_ev <= 1'b0;
    end else begin
      sync1   <= sw;
      sync2   <= sync1;
      rise_ev <= 1'b0;
      if (sync2 == level) begin
        // Any sample agreeing with the current level restarts the count,
        // so bounces shorter than DEBOUNCE_CYCLES never get through.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        level   <= sync2;
        cnt     <= '0;
        rise_ev <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/run_control.sv
// run_control: front-panel run/halt/single-step controller producing the
// processor clock enable.
//   Each switch is debounced by a switch_debounce instance; the resulting
//   events drive a 4-state FSM (HALTED, RUNNING, STOPPING, STEP). Halts only
//   complete on an instruction boundary (cpu_fetch). Event priority is
//   halt > run > step.
// Optional feature (macro RUN_CONTROL_BREAKPOINT_EN): address breakpoint
//   that halts directly from RUNNING on a matching fetch and sets bp_hit.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   sw_run, sw_halt, sw_step   raw front-panel switches
//   cpu_fetch                  first cycle of each instruction fetch
//   pc, bp_addr, bp_arm        breakpoint inputs (RUN_CONTROL_BREAKPOINT_EN only)
//   clk_en                     processor clock enable (registered)
//   running                    high in RUNNING and STOPPING
//   state                      current FSM state code (registered)
//   bp_hit                     sticky breakpoint-halt flag (0 without the feature)
module run_control
  import run_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ADDR_W          = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_run,
  input  logic              sw_halt,
  input  logic              sw_step,
  input  logic              cpu_fetch,
`ifdef RUN_CONTROL_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_arm,
`endif
  output logic              clk_en,
  output logic              running,
  output logic [1:0]        state,
  output logic              bp_hit
);

  if ((DEBOUNCE_CYCLES < 2) || (ADDR_W < 1)) begin : g_param_check
    $error("run_control: DEBOUNCE_CYCLES must be >= 2 and ADDR_W >= 1");
  end

  logic      run_ev;
  logic      halt_ev;
  logic      step_ev;
  logic      bp_match;
  rc_state_t state_r;
  rc_state_t next_state;
  logic      clk_en_r;
  logic      step_first_r;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .reset(reset), .sw(sw_run), .rise_ev(run_ev)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
    .clk(clk), .reset(reset), .sw(sw_halt), .rise_ev(halt_ev)
  );
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .reset(reset), .sw(sw_step), .rise_ev(step_ev)
  );

`ifdef RUN_CONTROL_BREAKPOINT_EN
  assign bp_match = bp_arm && cpu_fetch && (pc == bp_addr);
`else
  assign bp_match = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    next_state = state_r;
    case (state_r)
      ST_HALTED: begin
        // A coincident halt_ev masks run/step and is itself a no-op here.
        if (halt_ev) begin
          next_state = ST_HALTED;
        end else if (run_ev) begin
          next_state = ST_RUNNING;
        end else if (step_ev) begin
          next_state = ST_STEP;
        end else begin
          next_state = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        if (halt_ev) begin
          next_state = ST_STOPPING;
        end else if (bp_match) begin
          next_state = ST_HALTED;
        end else begin
          next_state = ST_RUNNING;
        end
      end
      ST_STOPPING: begin
        if (cpu_fetch) begin
          next_state = ST_HALTED;
        end else begin
          next_state = ST_STOPPING;
        end
      end
      ST_STEP: begin
        // The fetch seen in the first STEP cycle belongs to the instruction
        // being released; the following fetch ends the step.
        if (cpu_fetch && !step_first_r) begin
          next_state = ST_HALTED;
        end else begin
          next_state = ST_STEP;
        end
      end
      default: next_state = ST_HALTED;
    endcase
  end

  // State register and registered clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_HALTED;
      clk_en_r     <= 1'b0;
      step_first_r <= 1'b0;
    end else begin
      state_r      <= next_state;
      clk_en_r     <= (next_state != ST_HALTED);
      step_first_r <= (next_state == ST_STEP) && (state_r != ST_STEP);
    end
  end

`ifdef RUN_CONTROL_BREAKPOINT_EN
  logic bp_hit_r;
  logic bp_set;
  logic bp_clr;

  // Same condition the FSM uses, so halt_ev keeps priority over a match.
  assign bp_set = (state_r == ST_RUNNING) && !halt_ev && bp_match;
  assign bp_clr = run_ev || step_ev;

  // Sticky breakpoint flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit_r <= 1'b0;
    end else if (bp_set) begin
      bp_hit_r <= 1'b1;
    end else if (bp_clr) begin
      bp_hit_r <= 1'b0;
    end else begin
      bp_hit_r <= bp_hit_r;
    end
  end

  assign bp_hit = bp_hit_r;
`else
  assign bp_hit = 1'b0;
`endif

  assign clk_en  = clk_en_r;
  assign state   = state_r;
  assign running = is_running(state_r);

endmodule

// File: tb/tb_run_control.sv
// tb_run_control: self-checking bench for run_control (DEBOUNCE_CYCLES=16).
// Each test drives one stimulus cycle, pushes the expected outputs for the
// following edge onto a scoreboard queue, then pops and compares after the edge.
// Breakpoint test only built with RUN_CONTROL_BREAKPOINT_EN.
module tb_run_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw_run, sw_halt, sw_step, cpu_fetch;
  logic        clk_en, running, bp_hit;
  logic [1:0]  state;
`ifdef RUN_CONTROL_BREAKPOINT_EN
  logic [15:0] pc, bp_addr;
  logic        bp_arm;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] st;
    logic       bp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  run_control #(.DEBOUNCE_CYCLES(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .sw_run(sw_run), .sw_halt(sw_halt), .sw_step(sw_step),
    .cpu_fetch(cpu_fetch),
`ifdef RUN_CONTROL_BREAKPOINT_EN
    .pc(pc), .bp_addr(bp_addr), .bp_arm(bp_arm),
`endif
    .clk_en(clk_en), .running(running), .state(state), .bp_hit(bp_hit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] st, input logic bp);
    exp_t e;
    e.st = st;
    e.bp = bp;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      reset = (c < 4);
      push_exp(2'd0, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL reset c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
  endtask

  // 15-cycle pulse: one sample short of acceptance, must give no event.
  task automatic test_short_pulse();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      sw_run = (c < 15);
      push_exp(2'd0, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL short_pulse c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
  endtask

  // Switch edge at c=0; RUNNING visible after the 19th edge (index 18).
  task automatic test_run();
    exp_t e;
    for (int c = 0; c < 60; c++) begin
      sw_run = (c < 40);
      push_exp((c >= 18) ? 2'd1 : 2'd0, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL run c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
  endtask

  // Bounce c=0..4, clean rise at c=5 -> halt_ev after edge 23, STOPPING
  // seen at indices 23..29, fetch driven at c=30 -> HALTED at index 30.
  task automatic test_halt_bounce();
    exp_t e;
    logic [4:0] bounce;
    logic [1:0] st;
    bounce = 5'b01101;
    for (int c = 0; c < 60; c++) begin
      sw_halt   = (c < 5) ? bounce[c] : (c < 35);
      cpu_fetch = (c == 30);
      st = (c < 23) ? 2'd1 : (c < 30) ? 2'd2 : 2'd0;
      push_exp(st, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL halt_bounce c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
    cpu_fetch = 1'b0;
  endtask

  // STEP seen at indices 18..22; fetch at c=19 (first STEP cycle, ignored)
  // and c=23 (ends the step) -> clk_en high for exactly 5 cycles.
  task automatic test_step();
    exp_t e;
    for (int c = 0; c < 45; c++) begin
      sw_step   = (c < 20);
      cpu_fetch = (c == 19) || (c == 23);
      push_exp((c >= 18 && c <= 22) ? 2'd3 : 2'd0, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL step c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
    cpu_fetch = 1'b0;
  endtask

  // Coincident run and halt while HALTED: halt wins and is ignored.
  task automatic test_coincide();
    exp_t e;
    for (int c = 0; c < 50; c++) begin
      sw_run  = (c < 25);
      sw_halt = (c < 25);
      push_exp(2'd0, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL coincide c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
  endtask

  // sw_run held throughout; reset at c=48..50 during STOPPING, released at
  // c=51 -> run_ev 18 cycles later, RUNNING visible at index 69.
  task automatic test_reset_stopping();
    exp_t e;
    logic [1:0] st;
    for (int c = 0; c < 80; c++) begin
      sw_run  = 1'b1;
      sw_halt = (c >= 25 && c < 48);
      reset   = (c >= 48 && c <= 50);
      if (c < 18)      st = 2'd0;
      else if (c < 43) st = 2'd1;
      else if (c < 48) st = 2'd2;
      else if (c < 69) st = 2'd0;
      else             st = 2'd1;
      push_exp(st, 1'b0);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL reset_stopping c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
    reset = 1'b0;
  endtask

`ifdef RUN_CONTROL_BREAKPOINT_EN
  // Starts RUNNING. Non-matching pc (c=5) and disarmed match (c=7) ignored;
  // armed match at c=10 halts with bp_hit; run_ev (switch at c=30) clears it.
  task automatic test_breakpoint();
    exp_t e;
    logic [1:0] st;
    logic       bp;
    bp_addr = 16'h0123;
    for (int c = 0; c < 60; c++) begin
      sw_run    = (c >= 30 && c < 55);
      cpu_fetch = (c == 5) || (c == 7) || (c == 10);
      pc        = (c == 5) ? 16'h0122 : 16'h0123;
      bp_arm    = (c != 7);
      st = (c < 10) ? 2'd1 : (c < 48) ? 2'd0 : 2'd1;
      bp = (c >= 10 && c < 48);
      push_exp(st, bp);
      tick();
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || clk_en !== (e.st != 2'd0) || running !== (e.st == 2'd1 || e.st == 2'd2) || bp_hit !== e.bp) begin
        errors++;
        $display("FAIL breakpoint c=%0d got state=%0d clk_en=%b running=%b bp_hit=%b want state=%0d bp_hit=%b", c, state, clk_en, running, bp_hit, e.st, e.bp);
      end
    end
    cpu_fetch = 1'b0;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    sw_run    = 1'b0;
    sw_halt   = 1'b0;
    sw_step   = 1'b0;
    cpu_fetch = 1'b0;
`ifdef RUN_CONTROL_BREAKPOINT_EN
    pc      = 16'h0000;
    bp_addr = 16'h0000;
    bp_arm  = 1'b0;
`endif
    test_reset();
    test_short_pulse();
    test_run();
    test_halt_bounce();
    test_step();
    test_coincide();
    test_reset_stopping();
`ifdef RUN_CONTROL_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
